// File: rtl/multicycle_control.sv
// Moore control sequencer for the multicycle LEGv8 datapath (fetch, decode, memory, ALU, branch, trap).
// Optional macro ILLEGAL_TRAP_EN makes TRAP absorbing with illegal=1; otherwise TRAP is a one-cycle NOP.
module multicycle_control #(
    parameter int OPCODE_W = 11,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [3:0]          alu_control,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg2loc,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                pc_source,
    output logic                pc_en,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    localparam logic [STATE_W-1:0] ST_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] ST_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] ST_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] ST_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] ST_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] ST_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] ST_EXECUTE  = STATE_W'(6);
    localparam logic [STATE_W-1:0] ST_ALUWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] ST_CBZ      = STATE_W'(8);
    localparam logic [STATE_W-1:0] ST_BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] ST_TRAP     = STATE_W'(10);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    logic [STATE_W-1:0] state_reg, state_next;
    logic [3:0]         alu_op_reg, alu_op_next;
    logic               is_ldur, is_stur, is_rtype, is_cbz, is_b;

    assign is_ldur  = (opcode == OP_LDUR);
    assign is_stur  = (opcode == OP_STUR);
    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_ORR);
    assign is_cbz   = (opcode[10:3] == 8'b10110100);
    assign is_b     = (opcode[10:5] == 6'b000101);

    // The R-type ALU op is captured in DECODE so later IR changes cannot alter EXECUTE.
    always_comb begin
        case (opcode)
            OP_SUB:  alu_op_next = ALU_SUB;
            OP_AND:  alu_op_next = ALU_AND;
            OP_ORR:  alu_op_next = ALU_OR;
            default: alu_op_next = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_FETCH;
            alu_op_reg <= ALU_ADD;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_DECODE)
                alu_op_reg <= alu_op_next;
        end
    end

    always_comb begin
        state_next = ST_FETCH;
        case (state_reg)
            ST_FETCH:    state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (is_ldur || is_stur) state_next = ST_MEMADR;
                else if (is_rtype)      state_next = ST_EXECUTE;
                else if (is_cbz)        state_next = ST_CBZ;
                else if (is_b)          state_next = ST_BRANCH;
                else                    state_next = ST_TRAP;
            end
            ST_MEMADR:   state_next = is_ldur ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  state_next = mem_ready ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWRITE: state_next = mem_ready ? ST_FETCH : ST_MEMWRITE;
            ST_EXECUTE:  state_next = ST_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:     state_next = ST_TRAP;
`else
            ST_TRAP:     state_next = ST_FETCH;
`endif
            default:     state_next = ST_FETCH;
        endcase
    end

    // Outputs are decoded from state; reset overrides everything to the idle pattern.
    always_comb begin
        alu_control = 4'b0000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        reg2loc     = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        pc_source   = 1'b0;
        pc_en       = 1'b0;
        illegal     = 1'b0;
        if (!reset_n) begin
            alu_control = ALU_ADD;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    ir_write    = mem_ready;
                    pc_en       = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b   = 2'b11;
                    alu_control = ALU_ADD;
                    reg2loc     = is_stur || is_cbz;
                end
                ST_MEMADR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                ST_MEMREAD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                ST_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEMWRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                ST_EXECUTE: begin
                    alu_src_a   = 1'b1;
                    alu_control = alu_op_reg;
                end
                ST_ALUWB:    reg_write = 1'b1;
                ST_CBZ: begin
                    alu_control = ALU_PASS;
                    pc_source   = 1'b1;
                    pc_en       = zero;
                end
                ST_BRANCH: begin
                    pc_source = 1'b1;
                    pc_en     = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP:     illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected outputs are queued when stimulus is driven
// and compared on the falling edge. Honours ILLEGAL_TRAP_EN for the trap scenario.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  alu_control;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg2loc, iord, mem_read, mem_write, ir_write, reg_write;
    logic        mem_to_reg, pc_source, pc_en, illegal;
    logic [3:0]  state;

    multicycle_control #(.OPCODE_W(11), .STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg2loc(reg2loc), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_source(pc_source), .pc_en(pc_en), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] ac;
        logic       sa;
        logic [1:0] sb;
        logic       r2l, io, mr, mw, irw, rw, m2r, ps, pe, ill;
    } outs_t;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                           MW = 4'd5, EX = 4'd6, AWB = 4'd7, CB = 4'd8, BR = 4'd9, TR = 4'd10;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010100111;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    outs_t       exp_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [10:0] cur_op;
    outs_t       obs;

    assign obs = '{st: state, ac: alu_control, sa: alu_src_a, sb: alu_src_b, r2l: reg2loc,
                   io: iord, mr: mem_read, mw: mem_write, irw: ir_write, rw: reg_write,
                   m2r: mem_to_reg, ps: pc_source, pe: pc_en, ill: illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected outputs for a state, taken from the per-state output table.
    function automatic outs_t spec_out(input logic [3:0] st, input logic [10:0] op,
                                       input logic z, input logic rdy);
        outs_t o;
        o = '0;
        o.st = st;
        case (st)
            F:   begin o.mr = 1; o.sb = 2'b01; o.ac = 4'b0010; o.irw = rdy; o.pe = rdy; end
            D:   begin o.sb = 2'b11; o.ac = 4'b0010;
                       o.r2l = (op == OP_STUR) || (op[10:3] == 8'b10110100); end
            MA:  begin o.sa = 1; o.sb = 2'b10; o.ac = 4'b0010; end
            MR:  begin o.mr = 1; o.io = 1; end
            MWB: begin o.rw = 1; o.m2r = 1; end
            MW:  begin o.mw = 1; o.io = 1; end
            EX:  begin
                o.sa = 1;
                if (op == OP_SUB)      o.ac = 4'b0110;
                else if (op == OP_AND) o.ac = 4'b0000;
                else if (op == OP_ORR) o.ac = 4'b0001;
                else                   o.ac = 4'b0010;
            end
            AWB: o.rw = 1;
            CB:  begin o.ac = 4'b0111; o.ps = 1; o.pe = z; end
            BR:  begin o.ps = 1; o.pe = 1; end
`ifdef ILLEGAL_TRAP_EN
            TR:  o.ill = 1;
`endif
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            outs_t e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(obs), 32'(e));
        end
    end

    // One cycle of normal operation; called 1 time unit after a rising edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic rdy, input logic z);
        reset_n   = 1'b1;
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back(spec_out(st, cur_op, z, rdy));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc(input string tag);
        outs_t o;
        o = '0;
        o.ac = 4'b0010;
        reset_n   = 1'b0;
        mem_ready = 1'($urandom_range(1));
        zero      = 1'($urandom_range(1));
        exp_q.push_back(o);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(1));
    endfunction

    task automatic run_rtype(input logic [10:0] op, input string name);
        cur_op = op;
        opcode = op;
        cyc({name, "_fetch"}, F, 1, rnd());
        cyc({name, "_decode"}, D, rnd(), rnd());
        opcode = ~op;
        cyc({name, "_exec"}, EX, rnd(), rnd());
        cyc({name, "_wb"}, AWB, rnd(), rnd());
        $display("txn %s op=%b done", name, op);
    endtask

    initial begin
        reset_n = 1'b0; opcode = OP_BAD; zero = 1'b0; mem_ready = 1'b0; cur_op = OP_BAD;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_cyc("reset");
        $display("txn reset released");

        run_rtype(OP_ADD, "add");
        run_rtype(OP_SUB, "sub");
        run_rtype(OP_AND, "and");
        run_rtype(OP_ORR, "orr");

        cur_op = OP_LDUR; opcode = OP_LDUR;
        cyc("ldur_fetch", F, 0, 0);
        cyc("ldur_fetch", F, 0, 0);
        cyc("ldur_fetch", F, 1, 0);
        cyc("ldur_decode", D, 0, 0);
        cyc("ldur_memadr", MA, 0, 1);
        for (int i = 0; i < 3; i++) cyc("ldur_memread", MR, 0, 0);
        cyc("ldur_memread", MR, 1, 0);
        cyc("ldur_memwb", MWB, 0, 0);
        $display("txn ldur 10 cycles done");

        cur_op = OP_CBZ; opcode = OP_CBZ;
        cyc("cbz1_fetch", F, 1, 0);
        cyc("cbz1_decode", D, 1, 0);
        cyc("cbz1_taken", CB, rnd(), 1);
        $display("txn cbz zero=1 done");
        cyc("cbz0_fetch", F, 1, 1);
        cyc("cbz0_decode", D, 1, 1);
        cyc("cbz0_nottaken", CB, rnd(), 0);
        $display("txn cbz zero=0 done");

        cur_op = OP_STUR; opcode = OP_STUR;
        cyc("stur_fetch", F, 1, 0);
        cyc("stur_decode", D, 1, 0);
        cyc("stur_memadr", MA, 0, 0);
        cyc("stur_memwrite", MW, 0, 0);
        cyc("stur_memwrite", MW, 0, 0);
        cyc("stur_memwrite", MW, 1, 0);
        $display("txn stur done");

        cur_op = OP_B; opcode = OP_B;
        cyc("b_fetch", F, 1, 0);
        cyc("b_decode", D, 1, 0);
        cyc("b_branch", BR, 0, 0);
        $display("txn b done");

        // Reset in the middle of a load abandons it and restarts from FETCH.
        cur_op = OP_LDUR; opcode = OP_LDUR;
        cyc("ldur_abort_fetch", F, 1, 0);
        cyc("ldur_abort_decode", D, 1, 0);
        cyc("ldur_abort_memadr", MA, 1, 0);
        rst_cyc("ldur_abort_reset");
        cyc("ldur_abort_refetch", F, 0, 0);
        cyc("ldur_abort_refetch", F, 1, 0);
        cyc("ldur_abort_decode2", D, 1, 0);
        cyc("ldur_abort_memadr2", MA, 1, 0);
        cyc("ldur_abort_memread2", MR, 1, 0);
        cyc("ldur_abort_memwb2", MWB, 1, 0);
        $display("txn ldur abort by reset done");

        cur_op = OP_BAD; opcode = OP_BAD;
        cyc("trap_fetch", F, 1, 0);
        cyc("trap_decode", D, 1, 0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) cyc("trap_hold", TR, rnd(), rnd());
        rst_cyc("trap_reset");
        cyc("trap_after_reset", F, 1, 0);
`else
        cyc("trap_nop", TR, rnd(), rnd());
        cyc("trap_refetch", F, 0, 0);
`endif
        $display("txn illegal opcode done");

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control sequencer for the multicycle LEGv8 datapath. It is the driving end of the 64-bit ALU interface: per cycle it generates the 4-bit ALU control code and operand selects, and it consumes the ALU zero flag for CBZ.
- Moore FSM sits between the instruction register (opcode in) and the datapath muxes, register file, PC and memory (strobes out).
- Memory accesses are stalled by a ready handshake.

Parameters:
- OPCODE_W, 11, instruction bits [31:21] presented on opcode; fixed for LEGv8.
- STATE_W, 4, width of the state register and the state debug output.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- opcode  input  OPCODE_W  IR[31:21]; valid from DECODE onward.
- zero  input  1  ALU zero flag (result == 0).
- mem_ready  input  1  memory has completed the current read/write this cycle.
- alu_control  output  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass B.
- alu_src_a  output  1  0=PC, 1=reg A.
- alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm9, 11=branch offset<<2.
- reg2loc  output  1  1 = read Rt on register port 2 (STUR, CBZ).
- iord  output  1  memory address: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  load IR.
- reg_write  output  1  register file write.
- mem_to_reg  output  1  writeback source: 1=MDR, 0=ALUOut.
- pc_source  output  1  0=ALU result, 1=ALUOut.
- pc_en  output  1  PC load enable.
- illegal  output  1  trap indicator (see Optional Feature).
- state  output  STATE_W  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, CBZ=8, BRANCH=9, TRAP=10.
- Reset:
  - reset_n low → state=FETCH immediately (async).
  - While reset_n is low, all strobes are forced 0 (mem_read, mem_write, ir_write, reg_write, pc_en, illegal) and alu_control=0010; every other select is 0.
  - Reset asserted mid-instruction abandons the instruction with no partial write.
- Outputs are Moore (decoded from state). The two exceptions are pc_en and ir_write in FETCH (gated by mem_ready) and pc_en in CBZ (gated by zero).
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=0010, pc_source=0, ir_write=pc_en=mem_ready.
  - mem_ready → DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_control=0010 (branch target into ALUOut); reg2loc=1 when opcode is STUR or CBZ.
  - Transitions: LDUR 11111000010 / STUR 11111000000 → MEMADR; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → EXECUTE; CBZ 10110100xxx → CBZ; B 000101xxxxx → BRANCH; else → TRAP.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_control=0010.
  - LDUR → MEMREAD; STUR → MEMWRITE.
- MEMREAD:
  - Outputs: mem_read=1, iord=1.
  - mem_ready → MEMWB; otherwise hold.
- MEMWB:
  - Outputs: reg_write=1, mem_to_reg=1.
  - → FETCH.
- MEMWRITE:
  - Outputs: mem_write=1, iord=1.
  - mem_ready → FETCH; otherwise hold.
  - The strobe stays high until accepted.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00; alu_control = ADD 0010, SUB 0110, AND 0000, ORR 0001.
  - → ALUWB.
- ALUWB:
  - Outputs: reg_write=1, mem_to_reg=0.
  - → FETCH.
- CBZ:
  - Outputs: alu_src_b=00, alu_control=0111 (pass Rt), pc_source=1, pc_en=zero.
  - → FETCH. Taken when Rt==0.
- BRANCH:
  - Outputs: pc_source=1, pc_en=1.
  - → FETCH.
- TRAP: see Optional Feature.
- Cycle counts (with mem_ready always 1):
  - LDUR 5
  - STUR 4
  - R-type 4
  - CBZ 3
  - B 3
- Each mem_ready-low cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready is ignored in all other states.
- opcode is sampled only in DECODE and MEMADR; changes elsewhere have no effect.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - TRAP is absorbing; illegal=1 and all strobes are 0 until reset_n is asserted.
- ILLEGAL_TRAP_EN undefined:
  - TRAP drives all strobes 0 for one cycle and then goes to FETCH; the unrecognised instruction is a NOP (PC already advanced).
  - illegal is tied to 0.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release → state=0, all strobes 0 during reset; first FETCH cycle has mem_read=1, alu_control=0010, alu_src_b=01.
- ADD 10001011000, mem_ready=1 → states 0,1,6,7,0; alu_control=0010 in EXECUTE; reg_write=1 only in ALUWB. Repeat with SUB → 0110, AND → 0000, ORR → 0001.
- LDUR with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total; ir_write and pc_en pulse exactly once, in the final FETCH cycle; mem_to_reg=1 with reg_write in MEMWB.
- CBZ 10110100101 with zero=1 → pc_en=1, pc_source=1, alu_control=0111 in state 8. Same with zero=0 → pc_en=0 and return to FETCH.
- STUR 11111000000 → reg2loc=1 in DECODE; mem_write held across 2 mem_ready-low cycles, then FETCH; reg_write never asserted.
- Opcode 00000000000 → TRAP. With ILLEGAL_TRAP_EN: illegal=1 held 10+ cycles, cleared by reset_n. Without it: one cycle of all strobes 0, then FETCH.
